// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a skid buffer, hazard-bubble insertion, flush
// and a saturating stall counter. in_ready comes only from state flops, never from out_ready.
module pipe_stage_reg #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 10,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_bubble,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   main_data, skid_data;
  logic [CTRL_W-1:0]   main_ctrl, skid_ctrl;
  logic [CTRL_W-1:0]   in_ctrl_eff;
  logic                in_xfer, out_xfer;

  assign in_ready    = (state != SKID);
  assign out_valid   = (state != EMPTY);
  assign occupancy   = state;
  assign out_data    = main_data;
  assign out_ctrl    = main_ctrl;
  assign in_xfer     = in_valid && in_ready;
  assign out_xfer    = out_valid && out_ready;
  assign in_ctrl_eff = in_bubble ? CTRL_NOP : in_ctrl;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the payload registers are reset too because their reset
  // values are visible on out_data/out_ctrl.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= CTRL_NOP;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl_eff;
            state     <= FULL;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl_eff;
          end else if (out_xfer) begin
            state <= EMPTY;
          end else if (in_xfer) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl_eff;
            state     <= SKID;
          end
        end
        SKID: begin
          if (out_xfer) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            state     <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Counts stalled cycles independent of flush; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (CNT_W=4 to reach saturation quickly).
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 10;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_bubble;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              flush, cnt_clr;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP('0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .in_bubble(in_bubble),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .cnt_clr(cnt_clr), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
    check({tag, "_out_data"},  out_data,       32'd0);
    check({tag, "_out_ctrl"},  32'(out_ctrl),  32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0; in_bubble = 1'b0;
    out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    #3;
    check_reset_state("reset");

    // Single transfer with 1-cycle latency
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_data = 32'h0040_0004; in_ctrl = 10'h155; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_data",  out_data,       32'h0040_0004);
    check("lat_out_ctrl",  32'(out_ctrl),  32'h155);
    check("lat_occupancy", 32'(occupancy), 32'd1);
    @(negedge clk);
    check("drain_occupancy", 32'(occupancy), 32'd0);

    // Fill both registers under backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA; in_ctrl = 10'h001;
    @(negedge clk);
    in_data = 32'hB; in_ctrl = 10'h002;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hDD;   // must be refused while SKID
    check("skid_occupancy", 32'(occupancy), 32'd2);
    check("skid_in_ready",  32'(in_ready),  32'd0);
    check("skid_out_data",  out_data,       32'hA);
    check("skid_stall_cnt", 32'(stall_cnt), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_occupancy", 32'(occupancy), 32'd2);
    check("hold_out_data",  out_data,       32'hA);
    check("hold_out_ctrl",  32'(out_ctrl),  32'h001);
    check("hold_stall_cnt", 32'(stall_cnt), 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    check("order_second_data", out_data,       32'hB);
    check("order_second_ctrl", 32'(out_ctrl),  32'h002);
    check("order_occupancy",   32'(occupancy), 32'd1);
    @(negedge clk);
    check("order_empty_valid", 32'(out_valid), 32'd0);
    check("order_stall_cnt",   32'(stall_cnt), 32'd2);

    // Bubble replaces control with NOP, data untouched
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC; in_ctrl = 10'h3FF; in_bubble = 1'b1;
    @(negedge clk);
    in_bubble = 1'b0;
    check("bubble_out_data", out_data,      32'hC);
    check("bubble_out_ctrl", 32'(out_ctrl), 32'h000);

    // Flush in SKID discards a coincident push
    in_valid = 1'b1; in_data = 32'hE; in_ctrl = 10'h0AA;
    @(negedge clk);
    check("pre_flush_occupancy", 32'(occupancy), 32'd2);
    in_valid = 1'b1; in_data = 32'hF; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_occupancy", 32'(occupancy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready",  32'(in_ready),  32'd1);
    check("flush_stall_cnt", 32'(stall_cnt), 32'd4);

    // Back-to-back streaming through FULL
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11; in_ctrl = 10'h011;
    @(negedge clk);
    check("stream1_out_data", out_data, 32'h11);
    in_data = 32'h12; in_ctrl = 10'h012;
    @(negedge clk);
    in_valid = 1'b0;
    check("stream2_out_data",  out_data,       32'h12);
    check("stream2_occupancy", 32'(occupancy), 32'd1);
    @(negedge clk);
    check("stream_drain_occupancy", 32'(occupancy), 32'd0);

    // Counter clear, saturation, clear while stalled
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr_stall_cnt", 32'(stall_cnt), 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77; in_ctrl = 10'h077;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    check("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    check("sat_out_data",  out_data,       32'h77);
    @(negedge clk);
    check("sat_no_wrap", 32'(stall_cnt), 32'd15);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("sat_clr_stall_cnt", 32'(stall_cnt), 32'd0);

    // Asynchronous reset mid-cycle while in SKID
    in_valid = 1'b1; in_data = 32'h88; in_ctrl = 10'h088;
    @(negedge clk);
    check("pre_rst_occupancy", 32'(occupancy), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_occupancy", 32'(occupancy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
